gf163_mult_io: RTL and testbench

Operand/result front-end for the GF(2^163) interleaved multiplier. It collects two 163-bit operands from a 32-bit register-style write port and launches the multiplier. It holds the multiplier start handshake for the full operation, captures the product on completion, and clears the multiplier for the next run. The product is exposed on a 32-bit word-addressed read port. The block sits directly upstream and downstream of the multiplier, between the host bus and the multiplier.

---
 rtl/gf163_mult_io_if.sv | 36 +++
 rtl/gf163_mult_io.sv | 156 +++++++++++++++
 tb/tb_gf163_mult_io.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf163_mult_io_if.sv
// Host word port and multiplier handshake bundle for gf163_mult_io.
// Latency: none, wires only.
// Backpressure: none here; the slave side drops writes and go while busy.
interface gf163_mult_io_if;
    // host operand write port
    logic         wr_en;
    logic         wr_sel;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         go;
    // host status and result read port
    logic         busy;
    logic         res_valid;
    logic         err;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;
    // multiplier side
    logic [162:0] mult_a;
    logic [162:0] mult_b;
    logic         mult_start;
    logic         mult_rst;
    logic [162:0] mult_z;
    logic         mult_done;

    // front-end view
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, go, rd_addr, mult_z, mult_done,
        output busy, res_valid, err, rd_data, mult_a, mult_b, mult_start, mult_rst
    );

    // host plus multiplier view
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, go, rd_addr, mult_z, mult_done,
        input  busy, res_valid, err, rd_data, mult_a, mult_b, mult_start, mult_rst
    );
endinterface

// File: rtl/gf163_mult_io.sv
// GF(2^163) multiplier front-end: operand word writes, start/capture/clear sequencing, result word reads.
// Latency: start from the go edge; result valid 1 cycle after mult_done, idle 2 cycles after it.
// Backpressure: writes and go ignored while busy; optional RUN timeout under macro GF_IO_TIMEOUT_EN.
module gf163_mult_io #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    gf163_mult_io_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_CLEAR} state_t;

    state_t       state_q, state_d;
    logic [162:0] a_q, b_q, res_q;
    logic         mult_start_q, mult_start_d;
    logic         mult_rst_q, mult_rst_d;
    logic         res_valid_q, res_valid_d;
    logic         err_q, err_d;
    logic         wr_acc;
    logic         res_load;
    logic         timeout;

    // The run counter is 8 bits wide, so the limit has to fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
        $error("gf163_mult_io: TIMEOUT_CYC must be in 1..255");
    end

    // Only IDLE takes writes; word indices 6 and 7 do not exist.
    assign wr_acc = (state_q == S_IDLE) && bus.wr_en && (bus.wr_addr <= 3'd5);

`ifdef GF_IO_TIMEOUT_EN
    logic [7:0] run_cnt_q, run_cnt_d;

    // Count cycles spent in RUN; restarts from zero every time RUN is entered.
    always_comb begin
        run_cnt_d = (state_q == S_RUN) ? run_cnt_q + 8'd1 : 8'd0;
    end

    // Run counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_cnt_q <= 8'd0;
        else     run_cnt_q <= run_cnt_d;
    end

    // Fires on the TIMEOUT_CYC-th RUN cycle; a done in that same cycle wins.
    assign timeout = (state_q == S_RUN) && (run_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State and control output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mult_start_q <= 1'b0;
            mult_rst_q   <= 1'b1;
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mult_start_q <= mult_start_d;
            mult_rst_q   <= mult_rst_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
        end
    end

    // Next state: one operation is IDLE -> RUN -> CAPTURE -> CLEAR -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.go) state_d = S_RUN;
            S_RUN:     if (bus.mult_done || timeout) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_CLEAR;
            S_CLEAR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control outputs. start stays high for the whole RUN because the multiplier aborts if it drops;
    // the reset pulse in CAPTURE clears the multiplier's sticky done flag before the next run.
    always_comb begin
        mult_start_d = 1'b0;
        mult_rst_d   = 1'b0;
        res_valid_d  = res_valid_q;
        err_d        = err_q;
        res_load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_acc) res_valid_d = 1'b0;
                if (bus.go) begin
                    mult_start_d = 1'b1;
                    res_valid_d  = 1'b0;
                    err_d        = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.mult_done) begin
                    res_load = 1'b1;
                end else if (timeout) begin
                    err_d = 1'b1;
                end else begin
                    mult_start_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                res_valid_d = !err_q;
                mult_rst_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand words and the product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (wr_acc) begin
                for (int w = 0; w < 5; w++) begin
                    if (bus.wr_addr == 3'(w)) begin
                        if (bus.wr_sel) b_q[32*w +: 32] <= bus.wr_data;
                        else            a_q[32*w +: 32] <= bus.wr_data;
                    end
                end
                // word 5 only carries bits 162:160
                if (bus.wr_addr == 3'd5) begin
                    if (bus.wr_sel) b_q[162:160] <= bus.wr_data[2:0];
                    else            a_q[162:160] <= bus.wr_data[2:0];
                end
            end
            if (res_load) res_q <= bus.mult_z;
        end
    end

    // Result word read mux; nonexistent words read as zero.
    always_comb begin
        bus.rd_data = 32'd0;
        for (int w = 0; w < 5; w++) begin
            if (bus.rd_addr == 3'(w)) bus.rd_data = res_q[32*w +: 32];
        end
        if (bus.rd_addr == 3'd5) bus.rd_data = {29'd0, res_q[162:160]};
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.res_valid  = res_valid_q;
    assign bus.err        = err_q;
    assign bus.mult_a     = a_q;
    assign bus.mult_b     = b_q;
    assign bus.mult_start = mult_start_q;
    assign bus.mult_rst   = mult_rst_q;

endmodule

// File: tb/tb_gf163_mult_io.sv
// Directed bench for gf163_mult_io with a behavioural multiplier stub.
// Latency: stub completes a configurable number of cycles after start.
// Backpressure: stub done flag is sticky until mult_rst, like the real multiplier.
module tb_gf163_mult_io;

    localparam int TO = 60;
    localparam logic [162:0] POLY = 163'hC9;  // x^7 + x^6 + x^3 + 1

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   stub_lat = 5;
    bit   stub_en  = 1'b1;

    always #5 clk = ~clk;

    gf163_mult_io_if bus ();

    gf163_mult_io #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] r;
        logic [162:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) r = r ^ t;
            t = t[162] ? ((t << 1) ^ POLY) : (t << 1);
        end
        return r;
    endfunction

    // Multiplier stub: acts on the falling edge so its outputs are stable at the DUT's rising edge.
    initial begin : stub
        int   cnt;
        logic flag;
        cnt  = 0;
        flag = 1'b0;
        bus.mult_done = 1'b0;
        bus.mult_z    = '0;
        forever begin
            @(negedge clk);
            bus.mult_done = 1'b0;
            if (bus.mult_rst) begin
                cnt  = 0;
                flag = 1'b0;
            end else if (bus.mult_start && !flag) begin
                if (stub_en) begin
                    cnt++;
                    if (cnt >= stub_lat) begin
                        bus.mult_z    = gf_mul(bus.mult_a, bus.mult_b);
                        bus.mult_done = 1'b1;
                        flag          = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [162:0] got, input logic [162:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [2:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic check_result(input string tag, input logic [162:0] exp);
        logic [31:0] w;
        chk({tag, "_valid"}, bus.res_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus.rd_addr = 3'(i);
            #1;
            if (i < 5) w = exp[32*i +: 32];
            else       w = {29'd0, exp[162:160]};
            chk($sformatf("%s_w%0d", tag, i), bus.rd_data, w);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [162:0] e;
        int           n;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 32'd0;
        bus.go      = 1'b0;
        bus.rd_addr = 3'd0;

        // reset values
        tick();
        tick();
        chk("rst_busy",       bus.busy,       1'b0);
        chk("rst_res_valid",  bus.res_valid,  1'b0);
        chk("rst_err",        bus.err,        1'b0);
        chk("rst_mult_start", bus.mult_start, 1'b0);
        chk("rst_mult_rst",   bus.mult_rst,   1'b1);
        chk("rst_mult_a",     bus.mult_a,     163'd0);
        rst = 1'b0;
        tick();
        chk("rst_release_mult_rst", bus.mult_rst, 1'b0);

        // identity with cycle-accurate handshake timing
        wr(1'b0, 3'd0, 32'h1);
        wr(1'b1, 3'd0, 32'h1);
        pulse_go();
        chk("go_busy",  bus.busy,       1'b1);
        chk("go_start", bus.mult_start, 1'b1);
        n = 0;
        while (!bus.mult_done && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen",        bus.mult_done,  1'b1);
        chk("m0_start_low",     bus.mult_start, 1'b0);
        chk("m0_res_valid_low", bus.res_valid,  1'b0);
        tick();
        chk("m1_res_valid", bus.res_valid, 1'b1);
        chk("m1_mult_rst",  bus.mult_rst,  1'b1);
        chk("m1_busy",      bus.busy,      1'b1);
        tick();
        chk("m2_busy",     bus.busy,     1'b0);
        chk("m2_mult_rst", bus.mult_rst, 1'b0);
        check_result("ident", 163'd1);

        // out-of-range write is dropped; a real write clears res_valid
        wr(1'b0, 3'd6, 32'hFFFF_FFFF);
        chk("addr6_res_valid", bus.res_valid, 1'b1);
        chk("addr6_mult_a",    bus.mult_a,    163'd1);
        wr(1'b0, 3'd0, 32'h0);
        chk("wr_clears_valid", bus.res_valid, 1'b0);

        // reduction x^162 * x, with junk in the upper bits of word 5
        wr(1'b0, 3'd5, 32'hFFFF_FFFC);
        wr(1'b1, 3'd0, 32'h2);
        e = '0;
        e[162] = 1'b1;
        chk("w5_mask_mult_a", bus.mult_a, e);
        pulse_go();
        wait_idle("red");
        check_result("red", 163'hC9);

        // x^160 * x^2 lands in word 5; words 6 and 7 read zero
        wr(1'b0, 3'd5, 32'h1);
        wr(1'b1, 3'd0, 32'h4);
        pulse_go();
        wait_idle("w5");
        check_result("w5", e);
        bus.rd_addr = 3'd6;
        #1;
        chk("rd6_zero", bus.rd_data, 32'd0);
        bus.rd_addr = 3'd7;
        #1;
        chk("rd7_zero", bus.rd_data, 32'd0);

        // back-to-back: second go plus a B write on the cycle busy falls
        wr(1'b0, 3'd5, 32'h0);
        wr(1'b0, 3'd0, 32'h3);
        wr(1'b1, 3'd0, 32'h2);
        pulse_go();
        wait_idle("b2b1");
        chk("b2b1_valid", bus.res_valid, 1'b1);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 32'h3;
        pulse_go();
        bus.wr_en = 1'b0;
        chk("b2b2_busy",        bus.busy,      1'b1);
        chk("b2b2_valid_clear", bus.res_valid, 1'b0);
        wait_idle("b2b2");
        check_result("b2b2", 163'h5);

        // busy lockout: write and go during RUN are ignored
        stub_lat = 10;
        wr(1'b0, 3'd0, 32'h2);
        pulse_go();
        tick();
        tick();
        wr(1'b0, 3'd0, 32'hFFFF_FFFF);
        pulse_go();
        chk("lock_mult_a", bus.mult_a, 163'h2);
        wait_idle("lock");
        check_result("lock", 163'h6);
        tick();
        tick();
        tick();
        chk("lock_no_restart", bus.busy, 1'b0);
        stub_lat = 5;

        // reset 50 cycles into a long run
        stub_lat = 200;
        pulse_go();
        repeat (50) tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy",       bus.busy,       1'b0);
        chk("mrst_res_valid",  bus.res_valid,  1'b0);
        chk("mrst_err",        bus.err,        1'b0);
        chk("mrst_mult_start", bus.mult_start, 1'b0);
        chk("mrst_mult_rst",   bus.mult_rst,   1'b1);
        chk("mrst_rd0",        bus.rd_data,    32'd0);
        tick();
        tick();
        rst = 1'b0;
        stub_lat = 5;
        tick();
        wr(1'b0, 3'd0, 32'h1);
        wr(1'b1, 3'd0, 32'h1);
        pulse_go();
        wait_idle("post_rst");
        check_result("post_rst", 163'd1);

`ifdef GF_IO_TIMEOUT_EN
        // multiplier never answers: abort after TO RUN cycles
        stub_en = 1'b0;
        pulse_go();
        n = 0;
        while (!bus.err && n < TO + 20) begin
            tick();
            n++;
        end
        chk("to_cycles",    32'(n),        32'(TO));
        chk("to_err",       bus.err,       1'b1);
        chk("to_start_low", bus.mult_start, 1'b0);
        chk("to_valid0",    bus.res_valid, 1'b0);
        tick();
        chk("to_mult_rst",  bus.mult_rst,  1'b1);
        chk("to_valid1",    bus.res_valid, 1'b0);
        tick();
        chk("to_busy",      bus.busy,      1'b0);
        chk("to_rst_low",   bus.mult_rst,  1'b0);
        stub_en = 1'b1;
        pulse_go();
        chk("to_go_clears_err", bus.err, 1'b0);
        wait_idle("to_recover");
        check_result("to_recover", 163'd1);
`else
        // without the timeout, RUN waits as long as the multiplier takes
        stub_en = 1'b0;
        pulse_go();
        repeat (TO + 40) tick();
        chk("wait_busy",  bus.busy,       1'b1);
        chk("wait_start", bus.mult_start, 1'b1);
        chk("wait_err",   bus.err,        1'b0);
        stub_en = 1'b1;
        wait_idle("wait");
        check_result("wait", 163'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
